// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: RV32I load/store unit running one req/gnt/rvalid bus access and stalling the pipe until it completes.
// Define LSU_TIMEOUT_EN to add a watchdog that aborts accesses stuck longer than TIMEOUT_CYCLES.
module lsu_bus_ctrl
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  st_type,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic [31:0] rdata_out,
    output logic        lsu_stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;
    localparam logic [1:0] ST_SB  = 2'd1;
    localparam logic [1:0] ST_SH  = 2'd2;
    localparam logic [1:0] ST_SW  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        bus_we_q;
    logic [1:0]  off_q;
    logic [2:0]  ld_type_q;
    logic [31:0] rdata_q;

    logic        is_load, is_store, acc_byte, acc_half, acc_word;
    logic        misaligned, go;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        capture, abort, wd_expired;

    function automatic logic [31:0] extend_load(input logic [2:0]  lt,
                                                input logic [1:0]  off,
                                                input logic [31:0] raw);
        logic [31:0]        lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = raw >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (lt)
            LD_LB:   extend_load = 32'(lane_b);
            LD_LH:   extend_load = 32'(lane_h);
            LD_LBU:  extend_load = {24'h0, lane[7:0]};
            LD_LHU:  extend_load = {16'h0, lane[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // A load wins when both load and store are requested; ld_type 6/7 is not a load.
    always_comb begin
        is_load    = (ld_type >= LD_LB) && (ld_type <= LD_LHU);
        is_store   = !is_load && (st_type != 2'd0);
        acc_byte   = is_load ? ((ld_type == LD_LB) || (ld_type == LD_LBU)) : (st_type == ST_SB);
        acc_half   = is_load ? ((ld_type == LD_LH) || (ld_type == LD_LHU)) : (st_type == ST_SH);
        acc_word   = is_load ? (ld_type == LD_LW) : (st_type == ST_SW);
        misaligned = (is_load || is_store) &&
                     ((acc_half && addr[0]) || (acc_word && (addr[1:0] != 2'b00)));
        go         = (state_q == S_IDLE) && (is_load || is_store) && !misaligned;
    end

    always_comb begin
        be_d    = 4'hF;
        wdata_d = st_data;
        if (is_store) begin
            if (acc_byte) begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{st_data[7:0]}};
            end else if (acc_half) begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{st_data[15:0]}};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt) begin
                    if (bus_we_q) begin
                        state_d = S_DONE;
                    end else if (bus_rvalid) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            off_q       <= '0;
            ld_type_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                bus_addr_q  <= {addr[31:2], 2'b00};
                bus_be_q    <= be_d;
                bus_wdata_q <= wdata_d;
                bus_we_q    <= is_store;
                off_q       <= addr[1:0];
                ld_type_q   <= ld_type;
            end
            if (capture) begin
                rdata_q <= extend_load(ld_type_q, off_q, bus_rdata);
            end else if (abort && !bus_we_q) begin
                rdata_q <= '0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            bus_err_q;

    // Counts every cycle spent waiting on the bus; any other state clears it.
    always_comb begin
        wd_d = '0;
        if ((state_q == S_REQ) || (state_q == S_RESP)) wd_d = wd_q + 1'b1;
    end

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            bus_err_q <= abort;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign wd_expired = 1'b0;
    assign bus_err    = 1'b0;
`endif

    assign bus_req      = (state_q == S_REQ);
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign rdata_out    = rdata_q;
    assign misalign_err = (state_q == S_IDLE) && misaligned;
    assign lsu_stall    = go || (state_q == S_REQ) || (state_q == S_RESP);

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized scoreboard bench for lsu_bus_ctrl: a driver plays the pipeline and bus slave,
// a monitor checks bus requests and completed accesses against queued expectations.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ld_type;
    logic [1:0]  st_type;
    logic [31:0] addr, st_data;
    logic [31:0] rdata_out;
    logic        lsu_stall, misalign_err, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .ld_type(ld_type), .st_type(st_type), .addr(addr), .st_data(st_data),
        .rdata_out(rdata_out), .lsu_stall(lsu_stall), .misalign_err(misalign_err),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          stall;
    } cmp_exp_t;

    bus_exp_t    bus_q[$];
    cmp_exp_t    cmp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rdata = '0;
    int          run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] model_load(input int lt, input int off, input logic [31:0] raw);
        longint unsigned lane;
        longint          v;
        lane = raw / (64'd1 << (8 * off));
        case (lt)
            1: begin v = lane % 256;   if (v >= 128)   v = v - 256;   end
            2: begin v = lane % 65536; if (v >= 32768) v = v - 65536; end
            3: v = raw;
            4: v = lane % 256;
            5: v = lane % 65536;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // Monitor: bus fields must match the pending request every cycle bus_req is high;
    // each end of a stall run is one completed access.
    always @(negedge clk) begin
        if (reset) begin
            bus_q.delete();
            cmp_q.delete();
            run = 0;
        end else begin
            if (bus_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_bus_req", {31'b0, bus_req}, 32'd0);
                end else begin
                    check("bus_we", {31'b0, bus_we}, {31'b0, bus_q[0].we});
                    check("bus_addr", bus_addr, bus_q[0].addr);
                    check("bus_be", {28'b0, bus_be}, {28'b0, bus_q[0].be});
                    if (bus_q[0].we) check("bus_wdata", bus_wdata, bus_q[0].wdata);
                    if (bus_gnt) void'(bus_q.pop_front());
                end
            end
            if (lsu_stall) begin
                run++;
            end else if (run > 0) begin
                if (cmp_q.size() == 0) begin
                    check("unexpected_completion", run, 32'd0);
                end else begin
                    cmp_exp_t c;
                    c = cmp_q.pop_front();
                    check("rdata_out", rdata_out, c.rdata);
                    check("stall_cycles", run, c.stall);
                end
                run = 0;
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after the edge back into idle.
    task automatic run_op(input int ld, input int st, input logic [31:0] a, input logic [31:0] d,
                          input int gd, input int rd, input logic [31:0] raw);
        bit       is_ld, is_st, mis;
        int       size, off;
        bus_exp_t b;
        cmp_exp_t c;
        is_ld = (ld >= 1) && (ld <= 5);
        is_st = !is_ld && (st != 0);
        if (is_ld) size = (ld == 1 || ld == 4) ? 1 : (ld == 3) ? 4 : 2;
        else       size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
        off = a % 4;
        mis = (is_ld || is_st) && (off % size != 0);
        ld_type = ld[2:0];
        st_type = st[1:0];
        addr    = a;
        st_data = d;
        if (!(is_ld || is_st) || mis) begin
            @(negedge clk);
            check("misalign_err", {31'b0, misalign_err}, {31'b0, mis});
            check("noop_stall", {31'b0, lsu_stall}, 32'd0);
            check("noop_bus_req", {31'b0, bus_req}, 32'd0);
            check("noop_rdata", rdata_out, model_rdata);
            @(posedge clk); #1;
            ld_type = '0;
            st_type = '0;
            return;
        end
        b.we    = is_st;
        b.addr  = a & 32'hFFFF_FFFC;
        b.be    = !is_st ? 4'hF : (size == 1) ? 4'(1 << off) :
                  (size == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
        b.wdata = (size == 1) ? (d % 256) * 32'h0101_0101 :
                  (size == 2) ? (d % 65536) * 32'h0001_0001 : d;
        bus_q.push_back(b);
        if (is_ld) model_rdata = model_load(ld, off, raw);
        c.rdata = model_rdata;
        c.stall = 2 + gd + (is_ld ? rd : 0);
        cmp_q.push_back(c);

        @(posedge clk); #1;
        repeat (gd) begin @(posedge clk); #1; end
        bus_gnt = 1'b1;
        if (is_ld && rd == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = raw;
        end
        @(posedge clk); #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        if (is_ld && rd > 0) begin
            repeat (rd - 1) begin @(posedge clk); #1; end
            bus_rvalid = 1'b1;
            bus_rdata  = raw;
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
        end
        // Completion cycle: stray handshakes here must not start anything.
        if ($urandom_range(0, 3) == 0) begin
            bus_gnt    = 1'b1;
            bus_rvalid = 1'b1;
        end
        @(posedge clk); #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        ld_type    = '0;
        st_type    = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus_exp_t b;
        cmp_exp_t c;
        reset = 1'b1;
        ld_type = '0; st_type = '0; addr = '0; st_data = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", {28'b0, bus_be}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_stall", {31'b0, lsu_stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3, 0, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lw_rdata_const", rdata_out, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        run_op(1, 0, 32'h103, 32'h0, 1, 2, 32'h80FF_0000);
        @(negedge clk);
        check("lb_rdata_const", rdata_out, 32'hFFFF_FF80);
        @(posedge clk); #1;
        run_op(4, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        @(negedge clk);
        check("lbu_rdata_const", rdata_out, 32'h0000_0080);
        @(posedge clk); #1;
        run_op(0, 2, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0);
        run_op(3, 0, 32'h101, 32'h0, 0, 0, 32'h0);
        run_op(2, 3, 32'h105, 32'h0, 0, 0, 32'h0);
        run_op(0, 3, 32'h304, 32'hCAFE_F00D, 5, 0, 32'h0);

        // Store stalled on gnt, then reset during its third request cycle.
        st_type = 2'd3; addr = 32'h308; st_data = 32'h0BAD_CAFE;
        b.we = 1'b1; b.addr = 32'h308; b.be = 4'hF; b.wdata = 32'h0BAD_CAFE;
        bus_q.push_back(b);
        c.rdata = model_rdata; c.stall = 99;
        cmp_q.push_back(c);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        st_type = '0;
        @(negedge clk);
        check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'b0, lsu_stall}, 32'd0);
        check("mid_rst_rdata", rdata_out, 32'd0);
        check("mid_rst_bus_be", {28'b0, bus_be}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_rdata = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            run_op($urandom_range(0, 7), $urandom_range(0, 3),
                   {20'h0, 10'($urandom), 2'($urandom)}, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
        end

`ifdef LSU_TIMEOUT_EN
        // Load never granted: watchdog aborts after 16 request cycles.
        ld_type = 3'd3; addr = 32'h400;
        b.we = 1'b0; b.addr = 32'h400; b.be = 4'hF; b.wdata = 32'h0;
        bus_q.push_back(b);
        model_rdata = '0;
        c.rdata = 32'h0; c.stall = 17;
        cmp_q.push_back(c);
        repeat (17) begin @(posedge clk); #1; end
        if (bus_q.size() > 0) void'(bus_q.pop_front());
        @(negedge clk);
        check("timeout_bus_req", {31'b0, bus_req}, 32'd0);
        check("timeout_bus_err", {31'b0, bus_err}, 32'd1);
        check("timeout_stall", {31'b0, lsu_stall}, 32'd0);
        @(posedge clk); #1;
        ld_type = '0;
        @(negedge clk);
        check("timeout_err_pulse", {31'b0, bus_err}, 32'd0);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("cmp_q_drained", cmp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
